// File: rtl/lsu_ctrl.sv
// Load/store sequencer in front of the byte-addressable data memory: one request at a time,
// funct3/alignment checks, single-cycle memory access, load response and fault reporting.
module lsu_ctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter logic [2:0]  IDLE_CTRL = 3'b111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_store,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_base,
  input  logic [31:0]      req_offset,
  input  logic [31:0]      req_wdata,
  input  logic [4:0]       req_rd,
  output logic [2:0]       mem_read_ctrl,
  output logic [2:0]       mem_write_ctrl,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [4:0]       resp_rd,
  output logic             store_done,
  output logic             fault_valid,
  output logic [3:0]       fault_cause,
  output logic [31:0]      fault_addr,
  input  logic             fault_ack,
  output logic [CNT_W-1:0] load_count,
  output logic [CNT_W-1:0] store_count
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_FAULT} state_e;

  state_e           state_q, state_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             is_store_q, is_store_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [4:0]       resp_rd_q, resp_rd_d;
  logic             store_done_q, store_done_d;
  logic [3:0]       fault_cause_q, fault_cause_d;
  logic [31:0]      fault_addr_q, fault_addr_d;
  logic [CNT_W-1:0] load_count_q, load_count_d;
  logic [CNT_W-1:0] store_count_q, store_count_d;

  logic [31:0] ea;
  logic        legal;
  logic        misaligned;

  always_comb begin
    ea = req_base + req_offset;
    if (req_is_store) legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else              legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                              (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    // Only evaluated for legal codes, so x01 is a halfword and 010 a word.
    misaligned = ((req_funct3[1:0] == 2'b01) && ea[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
  end

  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    funct3_d      = funct3_q;
    is_store_d    = is_store_q;
    rd_d          = rd_q;
    resp_data_d   = resp_data_q;
    resp_rd_d     = resp_rd_q;
    store_done_d  = 1'b0;
    fault_cause_d = fault_cause_q;
    fault_addr_d  = fault_addr_q;
    load_count_d  = load_count_q;
    store_count_d = store_count_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!legal) begin
            fault_cause_d = 4'd2;
            fault_addr_d  = ea;
            state_d       = S_FAULT;
          end else if (misaligned) begin
            fault_cause_d = req_is_store ? 4'd6 : 4'd4;
            fault_addr_d  = ea;
            state_d       = S_FAULT;
          end else begin
            mem_addr_d  = ea;
            mem_wdata_d = req_wdata;
            funct3_d    = req_funct3;
            is_store_d  = req_is_store;
            rd_d        = req_rd;
            state_d     = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (is_store_q) begin
          store_count_d = store_count_q + CNT_W'(1);
          store_done_d  = 1'b1;
          state_d       = S_IDLE;
        end else begin
          resp_data_d  = mem_rdata;
          resp_rd_d    = rd_q;
          load_count_d = load_count_q + CNT_W'(1);
          state_d      = S_RESP;
        end
      end
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      S_FAULT: if (fault_ack)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      funct3_q      <= '0;
      is_store_q    <= 1'b0;
      rd_q          <= '0;
      resp_data_q   <= '0;
      resp_rd_q     <= '0;
      store_done_q  <= 1'b0;
      fault_cause_q <= '0;
      fault_addr_q  <= '0;
      load_count_q  <= '0;
      store_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      funct3_q      <= funct3_d;
      is_store_q    <= is_store_d;
      rd_q          <= rd_d;
      resp_data_q   <= resp_data_d;
      resp_rd_q     <= resp_rd_d;
      store_done_q  <= store_done_d;
      fault_cause_q <= fault_cause_d;
      fault_addr_q  <= fault_addr_d;
      load_count_q  <= load_count_d;
      store_count_q <= store_count_d;
    end
  end

  // Controls decode straight from the state flop so an async reset kills a write mid-access.
  assign mem_read_ctrl  = (state_q == S_ACCESS && !is_store_q) ? funct3_q : IDLE_CTRL;
  assign mem_write_ctrl = (state_q == S_ACCESS &&  is_store_q) ? funct3_q : IDLE_CTRL;

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign fault_valid = (state_q == S_FAULT);
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign resp_data   = resp_data_q;
  assign resp_rd     = resp_rd_q;
  assign store_done  = store_done_q;
  assign fault_cause = fault_cause_q;
  assign fault_addr  = fault_addr_q;
  assign load_count  = load_count_q;
  assign store_count = store_count_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed and randomized bench for lsu_ctrl against a byte-array reference memory model.
module tb_lsu_ctrl;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_is_store;
  logic [2:0]    req_funct3;
  logic [31:0]   req_base, req_offset, req_wdata;
  logic [4:0]    req_rd;
  logic [2:0]    mem_read_ctrl, mem_write_ctrl;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic          resp_valid, resp_ready;
  logic [31:0]   resp_data;
  logic [4:0]    resp_rd;
  logic          store_done, fault_valid, fault_ack;
  logic [3:0]    fault_cause;
  logic [31:0]   fault_addr;
  logic [CW-1:0] load_count, store_count;

  lsu_ctrl #(.CNT_W(CW), .IDLE_CTRL(3'b111)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_read_ctrl(mem_read_ctrl), .mem_write_ctrl(mem_write_ctrl),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_rd(resp_rd),
    .store_done(store_done), .fault_valid(fault_valid), .fault_cause(fault_cause),
    .fault_addr(fault_addr), .fault_ack(fault_ack),
    .load_count(load_count), .store_count(store_count)
  );

  always #5 clk = ~clk;

  // Environment memory (256 bytes, address bits above 7 ignored), driven only by DUT controls.
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256];

  always_comb begin
    logic [7:0] a;
    a = mem_addr[7:0];
    case (mem_read_ctrl)
      3'b000:  mem_rdata = {{24{mem[a][7]}}, mem[a]};
      3'b001:  mem_rdata = {{16{mem[a+8'd1][7]}}, mem[a+8'd1], mem[a]};
      3'b010:  mem_rdata = {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
      3'b100:  mem_rdata = {24'h0, mem[a]};
      3'b101:  mem_rdata = {16'h0, mem[a+8'd1], mem[a]};
      default: mem_rdata = 32'hA5A5A5A5;
    endcase
  end

  always @(posedge clk) begin
    case (mem_write_ctrl)
      3'b000: mem[mem_addr[7:0]] <= mem_wdata[7:0];
      3'b001: begin
        mem[mem_addr[7:0]]       <= mem_wdata[7:0];
        mem[mem_addr[7:0]+8'd1]  <= mem_wdata[15:8];
      end
      3'b010: begin
        mem[mem_addr[7:0]]       <= mem_wdata[7:0];
        mem[mem_addr[7:0]+8'd1]  <= mem_wdata[15:8];
        mem[mem_addr[7:0]+8'd2]  <= mem_wdata[23:16];
        mem[mem_addr[7:0]+8'd3]  <= mem_wdata[31:24];
      end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;
  int exp_loads = 0;
  int exp_stores = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: byte array, value assembled arithmetically, extension by range test.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] ea);
    int unsigned idx, b, h, w;
    idx = ea % 256;
    b = ref_mem[idx];
    h = b + 256 * ref_mem[(idx + 1) % 256];
    w = h + 65536 * (ref_mem[(idx + 2) % 256] + 256 * ref_mem[(idx + 3) % 256]);
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b) + 32'hFFFFFF00 : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h) + 32'hFFFF0000 : 32'(h);
      3'd2:    return 32'(w);
      3'd4:    return 32'(b);
      default: return 32'(h);
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] ea, input logic [31:0] wd);
    int unsigned n;
    n = 1 << f3;
    for (int unsigned i = 0; i < n; i++) ref_mem[(ea + i) % 256] = 8'((wd >> (8 * i)) & 255);
  endtask

  task automatic scramble_req();
    req_is_store = 1'($urandom);
    req_funct3   = 3'($urandom);
    req_base     = $urandom;
    req_offset   = $urandom;
    req_wdata    = $urandom;
    req_rd       = 5'($urandom);
  endtask

  task automatic run_req(input bit st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd,
                         input int bp);
    logic [31:0] ea, exp_data;
    bit          legal, aligned;
    int unsigned nbytes;
    logic [3:0]  cause;
    ea      = base + off;
    legal   = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    nbytes  = 1 << (f3 % 4);
    aligned = (ea % nbytes) == 0;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wd; req_rd = rd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    scramble_req();
    @(negedge clk);
    if (!legal || !aligned) begin
      cause = !legal ? 4'd2 : (st ? 4'd6 : 4'd4);
      chk("fault_valid", 32'(fault_valid), 32'd1);
      chk("fault_cause", 32'(fault_cause), 32'(cause));
      chk("fault_addr", fault_addr, ea);
      chk("fault_ctrl", {26'h0, mem_read_ctrl, mem_write_ctrl}, 32'h3F);
      chk("fault_req_ready", 32'(req_ready), 32'd0);
      repeat (2) begin
        req_valid = 1'b1;
        @(negedge clk);
        chk("fault_hold", {fault_valid, fault_cause, fault_addr[26:0]}, {1'b1, cause, ea[26:0]});
        chk("fault_counts", 32'({load_count, store_count}),
            32'({CW'(exp_loads), CW'(exp_stores)}));
      end
      req_valid = 1'b0; fault_ack = 1'b1;
      @(posedge clk);
      #1 fault_ack = 1'b0;
      @(negedge clk);
      chk("fault_cleared", {30'h0, fault_valid, req_ready}, 32'd1);
    end else begin
      chk("access_addr", mem_addr, ea);
      if (st) begin
        chk("access_ctrl", {26'h0, mem_read_ctrl, mem_write_ctrl}, {26'h0, 3'b111, f3});
        chk("access_wdata", mem_wdata, wd);
      end else begin
        chk("access_ctrl", {26'h0, mem_read_ctrl, mem_write_ctrl}, {26'h0, f3, 3'b111});
      end
      @(negedge clk);
      if (st) begin
        model_store(f3, ea, wd);
        exp_stores = (exp_stores + 1) % 16;
        chk("store_done", {30'h0, store_done, req_ready}, 32'd3);
        chk("store_count", 32'(store_count), 32'(exp_stores));
      end else begin
        exp_data = model_load(f3, ea);
        exp_loads = (exp_loads + 1) % 16;
        chk("resp_valid", {30'h0, resp_valid, req_ready}, 32'd2);
        chk("resp_data", resp_data, exp_data);
        chk("resp_rd", 32'(resp_rd), 32'(rd));
        chk("load_count", 32'(load_count), 32'(exp_loads));
        for (int i = 0; i < bp; i++) begin
          req_valid = 1'b1;
          scramble_req();
          @(negedge clk);
          chk("bp_stable", {resp_valid, req_ready, 25'h0, resp_rd}, {2'b10, 25'h0, rd});
          chk("bp_data", resp_data, exp_data);
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("resp_drop", {30'h0, resp_valid, req_ready}, 32'd1);
        chk("load_count_hold", 32'(load_count), 32'(exp_loads));
      end
    end
  endtask

  initial begin
    bit st;
    logic [2:0] f3;
    logic [31:0] base, tgt;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; fault_ack = 1'b0;
    scramble_req();
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {26'h0, mem_read_ctrl, mem_write_ctrl}, 32'h3F);
    chk("rst_flags", {28'h0, resp_valid, store_done, fault_valid, req_ready}, 32'd1);
    chk("rst_regs", resp_data | mem_addr | mem_wdata | fault_addr, 32'd0);
    chk("rst_small", {19'h0, resp_rd, fault_cause, load_count, store_count}, 32'd0);
    rst = 1'b0;

    // Store then load back
    run_req(1, 3'b010, 32'h10, 32'h4, 32'hDEADBEEF, 5'd0, 0);
    run_req(0, 3'b010, 32'h14, 32'h0, 32'h0, 5'd5, 0);
    // Sign versus zero extension
    run_req(1, 3'b000, 32'h21, 32'h0, 32'h00000080, 5'd0, 0);
    run_req(0, 3'b000, 32'h21, 32'h0, 32'h0, 5'd1, 0);
    run_req(0, 3'b100, 32'h21, 32'h0, 32'h0, 5'd2, 0);
    run_req(0, 3'b101, 32'h20, 32'h0, 32'h0, 5'd3, 0);
    // Faults
    run_req(0, 3'b010, 32'h20, 32'h2, 32'h0, 5'd4, 0);
    run_req(1, 3'b001, 32'h10, 32'h3, 32'h1234, 5'd0, 0);
    run_req(0, 3'b011, 32'h20, 32'h0, 32'h0, 5'd6, 0);
    run_req(1, 3'b100, 32'h20, 32'h0, 32'h0, 5'd7, 0);
    // Address wrap and response backpressure
    run_req(1, 3'b010, 32'hFFFFFFFC, 32'h8, 32'hCAFEF00D, 5'd0, 0);
    run_req(0, 3'b010, 32'hFFFFFFFC, 32'h8, 32'h0, 5'd9, 5);

    // Reset in the middle of a store access
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_base = 32'h8; req_offset = 32'h0; req_wdata = 32'h12345678; req_rd = 5'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("mid_access_ctrl", 32'(mem_write_ctrl), 32'd2);
    #1 rst = 1'b1;
    #1 chk("rst_kills_write", 32'(mem_write_ctrl), 32'd7);
    chk("rst_mid_regs", mem_addr | mem_wdata | resp_data, 32'd0);
    chk("rst_mid_small", {24'h0, load_count, store_count}, 32'd0);
    exp_loads = 0; exp_stores = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mem_unwritten", {mem[11], mem[10], mem[9], mem[8]},
        {ref_mem[11], ref_mem[10], ref_mem[9], ref_mem[8]});
    run_req(0, 3'b010, 32'h14, 32'h0, 32'h0, 5'd12, 1);

    // Store counter wraps at 2^CW
    for (int i = 0; i < 17; i++)
      run_req(1, 3'b010, 32'h40, 32'(4 * i), $urandom, 5'd0, 0);
    chk("store_wrap", 32'(store_count), 32'd1);

    // Random traffic in the low 256 bytes
    for (int i = 0; i < 80; i++) begin
      st   = 1'($urandom);
      f3   = 3'($urandom_range(0, 7));
      base = $urandom;
      tgt  = $urandom_range(0, 255);
      run_req(st, f3, base, tgt - base, $urandom, 5'($urandom), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
